window_builder: RTL and testbench

//  Raster-to-window producer feeding the 3x3 mean/edge filter stage. Accepts one 24-bit RGB pixel per

---
 rtl/cartoon_pkg.sv | 25 ++
 rtl/window_builder_if.sv | 24 ++
 rtl/line_buffer.sv | 27 ++
 rtl/window_builder.sv | 147 ++++++++++++++
 tb/tb_window_builder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cartoon_pkg.sv
// Shared types and constants for the cartoon filter pipeline: pixel and
// 3x3 window words, the window builder state encoding, and a counter-width helper.
package cartoon_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned WIN_W = 9 * PIX_W;

  typedef logic [PIX_W-1:0] pixel_t;

  // Element 8 is p0 (top-left, MSB) down to element 0 = p8 (newest pixel).
  typedef pixel_t [8:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SETTLE_WAIT,
    ACK_WAIT
  } wb_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_builder_if.sv
// Pixel-in / window-out handshake bundle of the window builder.
// slave = the builder, master = pixel source plus window consumer.
interface window_builder_if;
  import cartoon_pkg::*;

  logic    frame_start;
  logic    pix_valid;
  logic    pix_ready;
  pixel_t  pix_data;
  window_t window_data;
  logic    win_en;
  logic    win_done;
  logic    frame_done;

  modport slave (
    input  frame_start, pix_valid, pix_data, win_done,
    output pix_ready, window_data, win_en, frame_done
  );

  modport master (
    output frame_start, pix_valid, pix_data, win_done,
    input  pix_ready, window_data, win_en, frame_done
  );
endinterface

// File: rtl/line_buffer.sv
// One image row of storage: one write and one same-address read per cycle.
// The read is combinational, so it returns the previous row's value at this
// column while the write of the current row lands at the clock edge.
module line_buffer
  import cartoon_pkg::*;
#(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Row storage write; contents are never reset, each row is rewritten before use.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/window_builder.sv
// Raster-to-3x3-window producer. Buffers two previous rows, shifts a 3x3
// window per accepted pixel and hands each interior window to the consumer
// with a settle delay followed by an enable/done handshake.
// Optional: define WINDOW_BUILDER_COORD_EN to add win_row/win_col outputs
// carrying the centre-pixel coordinates of the presented window.
module window_builder
  import cartoon_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  window_builder_if.slave bus
`ifdef WINDOW_BUILDER_COORD_EN
  ,
  output logic [15:0] win_row,
  output logic [15:0] win_col
`endif
);

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);
  localparam int unsigned SW = cnt_w(SETTLE);

  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_H - 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE - 1);

  wb_state_t     state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] settle_cnt;
  logic          last_px;
  logic          pix_ready_q;
  logic          win_en_q;
  logic          frame_done_q;
  window_t       win_q;
  pixel_t        line_a_q;
  pixel_t        line_b_q;
  logic          accept;

  // A pixel raised together with frame_start belongs to the aborted frame.
  assign accept = (state == FILL) && bus.pix_valid && !bus.frame_start;

  assign bus.pix_ready   = pix_ready_q;
  assign bus.window_data = win_q;
  assign bus.win_en      = win_en_q;
  assign bus.frame_done  = frame_done_q;

  // line_a holds row r-1 and feeds line_b, which then holds row r-2.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_line_a (
    .clk     (clk),
    .we      (accept),
    .addr    (col),
    .wr_data (bus.pix_data),
    .rd_data (line_a_q)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_line_b (
    .clk     (clk),
    .we      (accept),
    .addr    (col),
    .wr_data (line_a_q),
    .rd_data (line_b_q)
  );

  // Frame sequencing, raster counters, window shift and handshake outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      settle_cnt   <= '0;
      last_px      <= 1'b0;
      pix_ready_q  <= 1'b0;
      win_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
`ifdef WINDOW_BUILDER_COORD_EN
      win_row      <= '0;
      win_col      <= '0;
`endif
    end else if (bus.frame_start) begin
      state        <= FILL;
      col          <= '0;
      row          <= '0;
      settle_cnt   <= '0;
      last_px      <= 1'b0;
      pix_ready_q  <= 1'b1;
      win_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state)
        IDLE: ;
        FILL: begin
          if (accept) begin
            // New right column = {row r-2, row r-1, row r}; older columns move left.
            win_q   <= {win_q[7], win_q[6], line_b_q,
                        win_q[4], win_q[3], line_a_q,
                        win_q[1], win_q[0], bus.pix_data};
            last_px <= (row == LAST_ROW) && (col == LAST_COL);
            if (col == LAST_COL) begin
              col <= '0;
              row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if ((row >= RW'(2)) && (col >= CW'(2))) begin
              state       <= SETTLE_WAIT;
              pix_ready_q <= 1'b0;
              settle_cnt  <= '0;
`ifdef WINDOW_BUILDER_COORD_EN
              win_row     <= 16'(row) - 16'd1;
              win_col     <= 16'(col) - 16'd1;
`endif
            end
          end
        end
        SETTLE_WAIT: begin
          if (settle_cnt == SETTLE_END) begin
            win_en_q <= 1'b1;
            state    <= ACK_WAIT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ACK_WAIT: begin
          if (bus.win_done) begin
            if (last_px) begin
              frame_done_q <= 1'b1;
              state        <= IDLE;
            end else begin
              pix_ready_q <= 1'b1;
              state       <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_builder.sv
// Directed bench for window_builder on a 4x4 image with SETTLE=2.
// Pixel n of a frame carries base+n in raster order.
module tb_window_builder;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic n_rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   win_cnt = 0;
  int   fd_cnt  = 0;

  window_builder_if bus ();

`ifdef WINDOW_BUILDER_COORD_EN
  logic [15:0] win_row;
  logic [15:0] win_col;
`endif

  window_builder #(.IMG_W(W), .IMG_H(H), .SETTLE(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
`ifdef WINDOW_BUILDER_COORD_EN
    ,
    .win_row (win_row),
    .win_col (win_col)
`endif
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (bus.win_en)     win_cnt <= win_cnt + 1;
    if (bus.frame_done) fd_cnt  <= fd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkw(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [215:0] win_of(input int base, input int r, input int c);
    logic [215:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[191:0], 24'(base + (r - 2 + i) * W + (c - 2 + j))};
    return w;
  endfunction

  // Optional idle gap (with a stray win_done pulse), then one accepted pixel.
  task automatic send(input logic [23:0] v, input int gap, input bit spurious);
    for (int g = 0; g < gap; g++) begin
      bus.pix_valid = 1'b0;
      bus.win_done  = spurious && (g == 0);
      tick();
    end
    bus.win_done  = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = v;
    for (int k = 0; k < 50 && !bus.pix_ready; k++) tick();
    chk1("ready_timeout", bus.pix_ready, 1'b1);
    tick();
    bus.pix_valid = 1'b0;
  endtask

  // Called one cycle after a window-completing accept.
  task automatic expect_window(input logic [215:0] exp, input int r, input int c,
                               input int ack_delay, input bit last);
    chk1("ready_drop", bus.pix_ready, 1'b0);
    chk1("en_early1", bus.win_en, 1'b0);
    chkw("win_shift", bus.window_data, exp);
    tick();
    chk1("en_early2", bus.win_en, 1'b0);
    tick();
    chk1("en_latency", bus.win_en, 1'b1);
    chkw("win_at_en", bus.window_data, exp);
`ifdef WINDOW_BUILDER_COORD_EN
    chkw("win_row", 216'(win_row), 216'(r - 1));
    chkw("win_col", 216'(win_col), 216'(c - 1));
`endif
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      chk1("hold_ready", bus.pix_ready, 1'b0);
      chk1("hold_en", bus.win_en, 1'b0);
      chkw("hold_win", bus.window_data, exp);
    end
    bus.win_done = 1'b1;
    tick();
    bus.win_done = 1'b0;
    chk1("frame_done", bus.frame_done, last);
    chk1("ready_after_ack", bus.pix_ready, !last);
    if (last) begin
      tick();
      chk1("frame_done_pulse", bus.frame_done, 1'b0);
      chk1("idle_ready", bus.pix_ready, 1'b0);
    end
  endtask

  // frame_start (with a same-cycle pixel that must be dropped), then a full frame.
  task automatic run_frame(input int base, input bit gaps, input int first_delay);
    int w0, f0, nwin;
    w0 = win_cnt;
    f0 = fd_cnt;
    nwin = 0;
    bus.pix_valid   = 1'b1;
    bus.pix_data    = 24'hABCDEF;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    chk1("fs_ready", bus.pix_ready, 1'b1);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(24'(base + r * W + c), gaps ? ((r * W + c) * 3) % 4 : 0, gaps);
        if (r >= 2 && c >= 2) begin
          expect_window(win_of(base, r, c), r, c, (nwin == 0) ? first_delay : 1,
                        (r == H - 1) && (c == W - 1));
          nwin++;
        end else begin
          chk1("ready_fill", bus.pix_ready, 1'b1);
        end
      end
    end
    chkw("win_count", 216'(win_cnt - w0), 216'(4));
    chkw("fd_count", 216'(fd_cnt - f0), 216'(1));
  endtask

  initial begin
    n_rst           = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.win_done    = 1'b0;

    // Reset held for three cycles.
    tick(); tick(); tick();
    chk1("rst_ready", bus.pix_ready, 1'b0);
    chkw("rst_win", bus.window_data, '0);
    chk1("rst_en", bus.win_en, 1'b0);
    chk1("rst_fd", bus.frame_done, 1'b0);
    n_rst = 1'b1;
    bus.win_done = 1'b1;
    tick();
    bus.win_done = 1'b0;
    chk1("idle_ready0", bus.pix_ready, 1'b0);
    chk1("idle_en0", bus.win_en, 1'b0);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk1("start_ready", bus.pix_ready, 1'b1);

    // Full frame, first window after pixel 10, prompt acks.
    run_frame(0, 1'b0, 1);
    // Long hold on the first window's ack.
    run_frame(200, 1'b0, 20);
    // Valid gaps with stray win_done while filling.
    run_frame(0, 1'b1, 1);
    // Abort mid row 2, then a new frame must not see stale rows.
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int n = 0; n < 9; n++) begin
      send(24'(50 + n), 0, 1'b0);
      chk1("abort_fill_ready", bus.pix_ready, 1'b1);
    end
    run_frame(100, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
